// File: rtl/icache_pkg.sv
// rtl/icache_pkg.sv - shared constants and FSM state type for the instruction cache
package icache_pkg;
  localparam int ARCH_LEN     = 32;
  localparam int ICACHE_LINES = 4;
  localparam int LINE_WORDS   = 4;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    MISS_REQ  = 2'd1,
    MISS_WAIT = 2'd2,
    REFILL    = 2'd3
  } icache_state_t;
endpackage

// File: rtl/icache_array.sv
// rtl/icache_array.sv - direct-mapped tag/data/valid storage, combinational read, refill write
module icache_array #(
  parameter int LINES  = 4,
  parameter int LINE_W = 128,
  parameter int TAG_W  = 26,
  parameter int IDX_W  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [IDX_W-1:0]  rd_idx,
  output logic              rd_valid,
  output logic [TAG_W-1:0]  rd_tag,
  output logic [LINE_W-1:0] rd_data,
  input  logic              wr_en,
  input  logic [IDX_W-1:0]  wr_idx,
  input  logic [TAG_W-1:0]  wr_tag,
  input  logic [LINE_W-1:0] wr_data
);
  logic [LINES-1:0]  valid_q, valid_d;
  logic [TAG_W-1:0]  tag_q  [LINES];
  logic [LINE_W-1:0] data_q [LINES];

  always_comb begin
    valid_d = valid_q;
    if (wr_en) valid_d[wr_idx] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) valid_q <= '0;
    else     valid_q <= valid_d;
  end

  // Tag and data contents are meaningless until the valid bit is set, so no reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag_q[wr_idx]  <= wr_tag;
      data_q[wr_idx] <= wr_data;
    end
  end

  assign rd_valid = valid_q[rd_idx];
  assign rd_tag   = tag_q[rd_idx];
  assign rd_data  = data_q[rd_idx];
endmodule

// File: rtl/icache.sv
// rtl/icache.sv - read-only direct-mapped instruction cache with zero-cycle hits and blocking line refill
module icache
  import icache_pkg::*;
#(
  parameter int ICACHE_LINES = icache_pkg::ICACHE_LINES,
  parameter int LINE_WORDS   = icache_pkg::LINE_WORDS
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req_valid,
  input  logic [ARCH_LEN-1:0]      req_addr,
  output logic                     resp_valid,
  output logic [31:0]              resp_inst,
  output logic                     stall_out,
  output logic                     mem_req_valid,
  input  logic                     mem_req_ready,
  output logic [ARCH_LEN-1:0]      mem_req_addr,
  input  logic                     mem_resp_valid,
  input  logic [32*LINE_WORDS-1:0] mem_resp_data
);
  localparam int WSEL_W = $clog2(LINE_WORDS);
  localparam int OFF_W  = WSEL_W + 2;
  localparam int IDX_W  = $clog2(ICACHE_LINES);
  localparam int TAG_W  = ARCH_LEN - OFF_W - IDX_W;
  localparam int LINE_W = 32 * LINE_WORDS;

  icache_state_t       state_q, state_d;
  logic [ARCH_LEN-1:0] miss_addr_q, miss_addr_d;

  logic [IDX_W-1:0]  req_idx, miss_idx;
  logic [TAG_W-1:0]  req_tag, miss_tag;
  logic [WSEL_W-1:0] req_word;
  logic              rd_valid, hit, refill_we;
  logic [TAG_W-1:0]  rd_tag;
  logic [LINE_W-1:0] rd_data;
  logic              unused_addr_bits;

  assign req_idx  = req_addr[OFF_W +: IDX_W];
  assign req_tag  = req_addr[ARCH_LEN-1 -: TAG_W];
  assign req_word = req_addr[2 +: WSEL_W];
  assign miss_idx = miss_addr_q[OFF_W +: IDX_W];
  assign miss_tag = miss_addr_q[ARCH_LEN-1 -: TAG_W];
  assign unused_addr_bits = ^{req_addr[1:0], miss_addr_q[OFF_W-1:0]};

  // Outputs are gated with rst so an asserted reset forces them quiet even while req_valid is high.
  assign hit       = !rst && (state_q == IDLE) && req_valid && rd_valid && (rd_tag == req_tag);
  assign refill_we = (state_q == MISS_WAIT) && mem_resp_valid;

  icache_array #(
    .LINES (ICACHE_LINES),
    .LINE_W(LINE_W),
    .TAG_W (TAG_W),
    .IDX_W (IDX_W)
  ) u_array (
    .clk     (clk),
    .rst     (rst),
    .rd_idx  (req_idx),
    .rd_valid(rd_valid),
    .rd_tag  (rd_tag),
    .rd_data (rd_data),
    .wr_en   (refill_we),
    .wr_idx  (miss_idx),
    .wr_tag  (miss_tag),
    .wr_data (mem_resp_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      miss_addr_q <= '0;
    end else begin
      state_q     <= state_d;
      miss_addr_q <= miss_addr_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    miss_addr_d = miss_addr_q;
    case (state_q)
      IDLE: begin
        if (req_valid && !hit) begin
          state_d     = MISS_REQ;
          miss_addr_d = req_addr;
        end
      end
      MISS_REQ:  if (mem_req_ready)  state_d = MISS_WAIT;
      MISS_WAIT: if (mem_resp_valid) state_d = REFILL;
      REFILL:    state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  always_comb begin
    resp_valid    = hit;
    resp_inst     = hit ? rd_data[{req_word, 5'b0} +: 32] : 32'd0;
    stall_out     = !rst && ((state_q != IDLE) || (req_valid && !hit));
    mem_req_valid = !rst && (state_q == MISS_REQ);
    mem_req_addr  = {miss_addr_q[ARCH_LEN-1:OFF_W], {OFF_W{1'b0}}};
  end
endmodule

// File: tb/tb_icache.sv
// tb/tb_icache.sv - directed and randomized bench for icache against a line-level reference model
module tb_icache;
  localparam int NL = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         req_valid;
  logic [31:0]  req_addr;
  logic         resp_valid;
  logic [31:0]  resp_inst;
  logic         stall_out;
  logic         mem_req_valid;
  logic         mem_req_ready;
  logic [31:0]  mem_req_addr;
  logic         mem_resp_valid;
  logic [127:0] mem_resp_data;

  int n_tests = 0;
  int n_fail  = 0;

  icache #(.ICACHE_LINES(NL), .LINE_WORDS(4)) dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid     (req_valid),
    .req_addr      (req_addr),
    .resp_valid    (resp_valid),
    .resp_inst     (resp_inst),
    .stall_out     (stall_out),
    .mem_req_valid (mem_req_valid),
    .mem_req_ready (mem_req_ready),
    .mem_req_addr  (mem_req_addr),
    .mem_resp_valid(mem_resp_valid),
    .mem_resp_data (mem_resp_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: what lines the cache holds and where the current miss is in its life.
  bit           m_v    [NL];
  logic [31:0]  m_tag  [NL];
  logic [127:0] m_line [NL];
  int           m_mode = 0;  // 0 lookup, 1 asking memory, 2 awaiting line, 3 refill bubble
  logic [31:0]  m_miss = '0;

  always @(negedge clk) begin
    logic        e_rv, e_st, e_mv;
    logic [31:0] e_inst;
    int          idx;
    e_rv = 0; e_st = 0; e_mv = 0; e_inst = '0;
    if (rst) begin
      m_mode = 0;
      for (int i = 0; i < NL; i++) m_v[i] = 0;
    end else begin
      case (m_mode)
        0: if (req_valid) begin
          idx = int'((req_addr >> 4) % NL);
          if (m_v[idx] && m_tag[idx] == (req_addr >> 6)) begin
            e_rv   = 1;
            e_inst = m_line[idx][32*((req_addr >> 2) % 4) +: 32];
          end else begin
            e_st   = 1;
            m_miss = req_addr;
            m_mode = 1;
          end
        end
        1: begin
          e_st = 1;
          e_mv = 1;
          check("mem_req_addr", mem_req_addr, m_miss & ~32'hF);
          if (mem_req_ready) m_mode = 2;
        end
        2: begin
          e_st = 1;
          if (mem_resp_valid) begin
            idx         = int'((m_miss >> 4) % NL);
            m_v[idx]    = 1;
            m_tag[idx]  = m_miss >> 6;
            m_line[idx] = mem_resp_data;
            m_mode      = 3;
          end
        end
        default: begin
          e_st   = 1;
          m_mode = 0;
        end
      endcase
    end
    check("resp_valid", resp_valid, e_rv);
    check("resp_inst", resp_inst, e_inst);
    check("stall_out", stall_out, e_st);
    check("mem_req_valid", mem_req_valid, e_mv);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic fill(input logic [31:0] a, input logic [127:0] d, input string nm);
    logic [127:0] line;
    line      = d;
    req_valid = 1;
    req_addr  = a;
    @(negedge clk);
    check({nm, "_miss_stall"}, stall_out, 1'b1);
    step();
    mem_req_ready = 1;
    step();
    mem_req_ready  = 0;
    mem_resp_valid = 1;
    mem_resp_data  = d;
    step();
    mem_resp_valid = 0;
    step();
    @(negedge clk);
    check({nm, "_hit_valid"}, resp_valid, 1'b1);
    check({nm, "_hit_inst"}, resp_inst, line[32*((a >> 2) % 4) +: 32]);
    step();
  endtask

  initial begin
    logic [127:0] line_a, line_d;
    line_a = 128'h3333_3333_2222_2222_1111_1111_0000_0000 ^ 128'hA5;
    line_d = 128'hDDDD_0003_DDDD_0002_DDDD_0001_DDDD_0000;
    rst = 1; req_valid = 0; req_addr = '0;
    mem_req_ready = 0; mem_resp_valid = 0; mem_resp_data = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_stall", stall_out, 1'b0);
    check("reset_resp_valid", resp_valid, 1'b0);
    check("reset_mem_req_valid", mem_req_valid, 1'b0);
    step();
    rst = 0;

    // Cold miss on 0x10, then memory back-pressure for five cycles.
    req_valid = 1; req_addr = 32'h10;
    @(negedge clk);
    check("cold_stall", stall_out, 1'b1);
    check("cold_resp_valid", resp_valid, 1'b0);
    step();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_mem_req_valid", mem_req_valid, 1'b1);
      check("bp_mem_req_addr", mem_req_addr, 32'h10);
      check("bp_stall", stall_out, 1'b1);
      step();
    end
    mem_req_ready = 1;
    step();
    mem_req_ready = 0;
    step();
    mem_resp_valid = 1; mem_resp_data = line_a;
    step();
    mem_resp_valid = 0;
    @(negedge clk);
    check("refill_stall", stall_out, 1'b1);
    check("refill_resp_valid", resp_valid, 1'b0);
    step();
    @(negedge clk);
    check("cold_hit_valid", resp_valid, 1'b1);
    check("cold_hit_word0", resp_inst, line_a[31:0]);
    check("cold_hit_stall", stall_out, 1'b0);
    step();
    req_addr = 32'h1C;
    @(negedge clk);
    check("hit_1c_valid", resp_valid, 1'b1);
    check("hit_1c_word3", resp_inst, line_a[127:96]);
    check("hit_1c_no_mem_req", mem_req_valid, 1'b0);
    step();

    // Conflict on index 0.
    fill(32'h00, {4{32'h0BAD_0000}} ^ 128'h1, "conf_00");
    fill(32'h40, {4{32'h4040_4040}}, "conf_40");
    fill(32'h00, {4{32'h0000_BEEF}}, "conf_00_again");

    // Redirect while waiting for the 0x100 line.
    req_valid = 1; req_addr = 32'h100;
    step();
    mem_req_ready = 1;
    step();
    mem_req_ready = 0; req_addr = 32'h200;
    @(negedge clk);
    check("redirect_wait_stall", stall_out, 1'b1);
    step();
    mem_resp_valid = 1; mem_resp_data = line_d;
    step();
    mem_resp_valid = 0; req_addr = 32'h100;
    step();
    @(negedge clk);
    check("redirect_100_hit", resp_valid, 1'b1);
    check("redirect_100_inst", resp_inst, line_d[31:0]);
    step();
    req_addr = 32'h200;
    @(negedge clk);
    check("redirect_200_miss", stall_out, 1'b1);
    check("redirect_200_no_resp", resp_valid, 1'b0);
    step();
    rst = 1;
    step();
    rst = 0;

    // Reset in the middle of awaiting a line, then a stale memory response.
    req_addr = 32'h100;
    step();
    mem_req_ready = 1;
    step();
    mem_req_ready = 0; req_valid = 0; rst = 1;
    @(negedge clk);
    check("midreset_stall", stall_out, 1'b0);
    check("midreset_mem_req_valid", mem_req_valid, 1'b0);
    step();
    rst = 0; mem_resp_valid = 1; mem_resp_data = line_d;
    step();
    mem_resp_valid = 0; req_valid = 1; req_addr = 32'h100;
    @(negedge clk);
    check("late_resp_ignored_miss", stall_out, 1'b1);
    check("late_resp_no_hit", resp_valid, 1'b0);
    step();

    // Random traffic from a small address pool so hits, conflicts and redirects all occur.
    for (int c = 0; c < 3000; c++) begin
      rst            = ($urandom % 200) == 0;
      req_valid      = ($urandom % 4) != 0;
      req_addr       = ($urandom_range(0, 3) << 6) | ($urandom_range(0, 3) << 4) | $urandom_range(0, 15);
      mem_req_ready  = ($urandom % 2) == 0;
      mem_resp_valid = ($urandom % 4) == 0;
      mem_resp_data  = {$urandom, $urandom, $urandom, $urandom};
      step();
    end
    rst = 0; req_valid = 0; mem_resp_valid = 0;
    step();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
